// File: rtl/seq_mul_pkg.sv
// Shared constants, state encoding and helpers for the sequential 4x4 multiplier.
package seq_mul_pkg;

  localparam int N    = 4;
  localparam int ITER = N;
  localparam int PW   = 2 * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gate-level 2-bit increment, so the controller needs no behavioural adder.
  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return {c[1] ^ c[0], ~c[0]};
  endfunction

endpackage

// File: rtl/top_adder.sv
// 4-bit ripple-carry adder; the only arithmetic resource of the multiplier.
module top_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[4];

endmodule

// File: rtl/seq_mul_ctrl.sv
// Shift-and-add 4x4 unsigned multiplier controller; one shared adder pass per cycle,
// product valid on a one-cycle done pulse five edges after the accepted start.
module seq_mul_ctrl
  import seq_mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] product
);

  localparam logic [1:0] LAST = 2'(ITER - 1);

  state_t        r_state;
  logic [1:0]    r_cnt;
  logic [N-1:0]  r_mcand;
  logic [N-1:0]  r_acc_hi;
  logic [N-1:0]  r_acc_lo;
  logic          r_busy;
  logic          r_done;
  logic [PW-1:0] r_product;

  logic [N-1:0]  w_addend;
  logic [N-1:0]  w_sum;
  logic          w_cout;

  assign w_addend = r_acc_lo[0] ? r_mcand : 4'h0;

  top_adder u_adder (
    .a    (r_acc_hi),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Controller FSM, accumulator shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_mcand   <= 4'h0;
      r_acc_hi  <= 4'h0;
      r_acc_lo  <= 4'h0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= a;
            r_acc_lo <= b;
            r_acc_hi <= 4'h0;
            r_cnt    <= 2'd0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          // {cout,sum,acc_lo} >> 1, truncated to 8 bits.
          r_acc_hi <= {w_cout, w_sum[3:1]};
          r_acc_lo <= {w_sum[0], r_acc_lo[3:1]};
          r_cnt    <= cnt_inc(r_cnt);
          r_busy   <= 1'b1;
          if (r_cnt == LAST) begin
            r_product <= {w_cout, w_sum, r_acc_lo[3:1]};
            r_done    <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_done  <= 1'b0;
            r_state <= RUN;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: doc/seq_mul_ctrl.md
Name: seq_mul_ctrl

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier controller. It produces an 8-bit product.
- All arithmetic goes through one 4-bit ripple-carry adder (top_adder), with cin tied to 0. The controller sequences that adder over 4 iterations, one per cycle.
- It sits between a requester (start pulse plus operands) and the shared adder datapath. It replaces a combinational array multiplier at 1/4 the adder cost.

Parameters:
- N, 4, operand width. Fixed to 4 to match top_adder; any other value is unsupported.
- ITER, N, number of add/shift iterations. Derived from N; not to be overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request strobe; sampled only in IDLE.
- a  in  4  multiplicand; captured on accepted start.
- b  in  4  multiplier; captured on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; product valid this cycle.
- product  out  8  result; held until the next accepted start.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - state=IDLE, cnt=0.
  - mcand, acc_hi, acc_lo, carry all cleared to 0.
  - busy=0, done=0, product=8'h00.
- Reset release is used synchronously (synchronised deassertion is the top level's responsibility).
- State IDLE:
  - busy=0.
  - start=1 at edge E captures mcand<=a, acc_lo<=b, acc_hi<=0, cnt<=0, and moves to RUN.
  - product is not cleared on start; it keeps its old value until the new done.
- State RUN, one iteration per edge:
  - Adder inputs: a=acc_hi, b=(acc_lo[0] ? mcand : 4'h0), cin=0.
  - Next {acc_hi, acc_lo} <= {cout, sum, acc_lo} >> 1, i.e. a 9-bit right shift with the 9-bit result truncated to 8.
  - cnt increments on each iteration.
  - After the iteration at cnt==ITER-1, go to DONE and load product <= {acc_hi', acc_lo'}.
  - cnt is 2 bits. Its wrap from 3 to 0 coincides with leaving RUN; it is never used to re-enter RUN.
- State DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge E; RUN iterations on edges E+1..E+4; done high in cycle E+4..E+5. Total 5 edges from start to done. Back-to-back throughput is 1 product per 6 cycles.
- start handling:
  - start while RUN or DONE: ignored, no queuing.
  - A start held high is re-accepted on the first IDLE cycle.
- Operand changes on a/b after capture: no effect.
- Overflow is impossible: 15*15=225 fits in 8 bits, and the 9th shift bit is always 0 at the final step.
- Reset mid-RUN: immediate abort, all state cleared, no done pulse, product=0.
- Unknown state encoding: recovers to IDLE on the next edge.
- Outputs are registered: busy and done decode directly from state flops, and product is a flop.

Decomposition:
- Shared package (seq_mul_pkg):
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - N=4 and ITER constant.
  - Product width 2*N.
- One sub-module: the existing top_adder, instantiated once as the only arithmetic resource. No behavioural "+" is allowed in seq_mul_ctrl.
- The FSM and shift register stay in seq_mul_ctrl; no further split.

Test Plan:
- Basic product: rst_n low 3 cycles then high; a=4'hF, b=4'hF, start 1 cycle. Required: busy=1 for 5 cycles, done=1 on the 5th cycle after acceptance, product=8'hE1 (225), then busy=0.
- Zero and identity cases:
  - a=4'h9, b=4'h6 -> product=8'h36 (54).
  - a=4'h0, b=4'hB -> 8'h00.
  - a=4'h7, b=4'h1 -> 8'h07.
  - Each done pulse is exactly 1 cycle wide.
- start ignored while busy: start a=3, b=5. Pulse start with a=4'hF, b=4'hF on RUN cycle 2 and again on the DONE cycle. Required: product=8'h0F, only one done pulse, FSM back in IDLE.
- Held start: start held high continuously with a=2, b=3. Required: done every 6 cycles, product=8'h06 each time, no cycle where busy=0 and start is missed beyond the single IDLE cycle.
- Reset mid-operation: a=4'hD, b=4'hE, start, then assert rst_n=0 asynchronously between edges during RUN. Required: busy, done and product go to 0 immediately, with no done pulse after release. A subsequent a=4'hD, b=4'hE gives 8'hB6 (182).
- Exhaustive sweep: all 256 (a,b) pairs back-to-back. Required: product == a*b on every done, and done count == 256.
